// File: rtl/demo_io_bus.sv
`default_nettype none
// ============================================================================
//  Module   : demo_io_bus
//  Purpose  : Address decoder and memory-mapped I/O block for a small 8-bit
//             processor. Routes accesses to external synchronous RAM or to an
//             internal register file holding a key FIFO, a 1 ms timer, an LED
//             register and an interrupt enable.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock_25   in   1   system clock, rising edge
//    reset_n    in   1   asynchronous active-low reset
//    cpu_addr   in  16   processor address
//    cpu_wdata  in   8   processor write data
//    cpu_wr     in   1   processor write strobe
//    cpu_rdata  out  8   read data to processor (one-cycle latency)
//    ram_addr   out 16   RAM address (pass-through)
//    ram_wdata  out  8   RAM write data (pass-through)
//    ram_wr     out  1   RAM write enable (RAM region only)
//    ram_rdata  in   8   RAM synchronous-read data
//    key_valid  in   1   one-cycle key strobe
//    key_code   in   8   key code
//    o_led      out  8   LED register
//    o_irq      out  1   key interrupt request
// ============================================================================
module demo_io_bus #(
   parameter int FIFO_DEPTH = 8,
   parameter int TICK_DIV   = 25000
) (
   input  logic        clock_25,
   input  logic        reset_n,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_wr,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] ram_addr,
   output logic [7:0]  ram_wdata,
   output logic        ram_wr,
   input  logic [7:0]  ram_rdata,
   input  logic        key_valid,
   input  logic [7:0]  key_code,
   output logic [7:0]  o_led,
   output logic        o_irq
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_FULL   = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   // Read-path source. SEL_NONE exists so cpu_rdata is 0x00 straight out of
   // reset, before the first access has been registered.
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_RAM  = 2'd1,
      SEL_IO   = 2'd2
   } sel_e;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   sel_e            sel_q,      sel_d;
   logic [7:0]      rdata_q,    rdata_d;
   logic [AW-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [CW-1:0]   count_q,    count_d;
   logic            ovf_q,      ovf_d;
   logic [PW-1:0]   presc_q,    presc_d;
   logic [15:0]     timer_q,    timer_d;
   logic [7:0]      shadow_q,   shadow_d;
   logic [7:0]      led_q,      led_d;
   logic            ien_q,      ien_d;
   logic            irq_q,      irq_d;
   logic            key_rd_prev_q, key_rd_prev_d;
   logic [7:0]      fifo_mem_q [FIFO_DEPTH];

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic       io_hit, io_rd, io_wr;
   logic [2:0] idx;
   logic       key_rd, pop_first;
   logic       fifo_empty, fifo_full;
   logic       do_pop, do_push, ovf_set;
   logic [7:0] io_val;

   assign io_hit     = (cpu_addr[15:3] == 13'h1FE0);
   assign idx        = cpu_addr[2:0];
   assign io_rd      = io_hit & ~cpu_wr;
   assign io_wr      = io_hit &  cpu_wr;

   assign ram_addr   = cpu_addr;
   assign ram_wdata  = cpu_wdata;
   assign ram_wr     = cpu_wr & ~io_hit;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CNT_FULL);

   // A held KEY read pops only on its first cycle.
   assign key_rd     = io_rd & (idx == 3'd1);
   assign pop_first  = key_rd & ~key_rd_prev_q;
   assign do_pop     = pop_first & ~fifo_empty;
   // A full FIFO still accepts a key if a pop frees a slot on the same edge.
   assign do_push    = key_valid & (~fifo_full | do_pop);
   assign ovf_set    = key_valid & fifo_full & ~do_pop;

   // ------------------------------------------------------------------
   // I/O read value
   // ------------------------------------------------------------------
   always_comb begin
      io_val = 8'h00;
      case (idx)
         3'd0:    io_val = {5'b0, ovf_q, fifo_full, ~fifo_empty};
         3'd1:    io_val = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];
         3'd2:    io_val = timer_q[7:0];
         3'd3:    io_val = shadow_q;
         3'd4:    io_val = led_q;
         3'd6:    io_val = {7'b0, ien_q};
         default: io_val = 8'h00;
      endcase
   end

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      sel_d         = io_hit ? SEL_IO : SEL_RAM;
      // Keep the first KEY value visible while the read is held, since the
      // head has already moved on.
      rdata_d       = (key_rd & key_rd_prev_q) ? rdata_q : io_val;
      key_rd_prev_d = key_rd;

      wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      ovf_d = ovf_q;
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (io_wr && idx == 3'd0) begin
         ovf_d = 1'b0;
      end

      // Timer: a byte write restarts the prescaler and wins over a tick.
      presc_d = presc_q;
      timer_d = timer_q;
      if (io_wr && idx == 3'd2) begin
         timer_d = {timer_q[15:8], cpu_wdata};
         presc_d = '0;
      end else if (io_wr && idx == 3'd3) begin
         timer_d = {cpu_wdata, timer_q[7:0]};
         presc_d = '0;
      end else if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         timer_d = timer_q + 16'd1;
      end else begin
         presc_d = presc_q + PW'(1);
      end

      // Reading the low byte freezes the high byte for a coherent 16-bit read.
      shadow_d = (io_rd && idx == 3'd2) ? timer_q[15:8] : shadow_q;
      led_d    = (io_wr && idx == 3'd4) ? cpu_wdata     : led_q;
      ien_d    = (io_wr && idx == 3'd6) ? cpu_wdata[0]  : ien_q;
      irq_d    = ien_q & ~fifo_empty;
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock_25 or negedge reset_n) begin
      if (!reset_n) begin
         sel_q         <= SEL_NONE;
         rdata_q       <= 8'h00;
         key_rd_prev_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         ovf_q         <= 1'b0;
         presc_q       <= '0;
         timer_q       <= 16'h0000;
         shadow_q      <= 8'h00;
         led_q         <= 8'h00;
         ien_q         <= 1'b0;
         irq_q         <= 1'b0;
      end else begin
         sel_q         <= sel_d;
         rdata_q       <= rdata_d;
         key_rd_prev_q <= key_rd_prev_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         ovf_q         <= ovf_d;
         presc_q       <= presc_d;
         timer_q       <= timer_d;
         shadow_q      <= shadow_d;
         led_q         <= led_d;
         ien_q         <= ien_d;
         irq_q         <= irq_d;
      end
   end

   // FIFO storage needs no reset: entries are only visible via count.
   always_ff @(posedge clock_25) begin
      if (do_push) begin
         fifo_mem_q[wr_ptr_q] <= key_code;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      cpu_rdata = 8'h00;
      case (sel_q)
         SEL_IO:  cpu_rdata = rdata_q;
         SEL_RAM: cpu_rdata = ram_rdata;
         default: cpu_rdata = 8'h00;
      endcase
   end

   assign o_led = led_q;
   assign o_irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_demo_io_bus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demo_io_bus
//  Purpose  : Self-checking bench for demo_io_bus: a vector table for
//             single-cycle accesses plus hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demo_io_bus;

   localparam int TDIV = 10;
   localparam logic [15:0] IDLE = 16'h0100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_wr;
   logic [7:0]  cpu_rdata;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic        ram_wr;
   logic [7:0]  ram_rdata;
   logic        key_valid;
   logic [7:0]  key_code;
   logic [7:0]  o_led;
   logic        o_irq;

   int checks   = 0;
   int failures = 0;

   demo_io_bus #(.FIFO_DEPTH(8), .TICK_DIV(TDIV)) dut (
      .clock_25  (clk),
      .reset_n   (reset_n),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_wr    (cpu_wr),
      .cpu_rdata (cpu_rdata),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_wr    (ram_wr),
      .ram_rdata (ram_rdata),
      .key_valid (key_valid),
      .key_code  (key_code),
      .o_led     (o_led),
      .o_irq     (o_irq)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM model (256 bytes, low address byte).
   logic [7:0] ram_mem [256];
   always @(posedge clk) begin
      if (ram_wr) ram_mem[ram_addr[7:0]] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr[7:0]];
   end

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        wr;
      logic        kv;
      logic [7:0]  kc;
      logic        chk;
      logic [7:0]  exp_rd;
      logic        exp_ramwr;
   } vec_t;

   function automatic vec_t mkv(logic [15:0] a, logic [7:0] d, logic w, logic kv,
                                logic [7:0] kc, logic c, logic [7:0] e, logic rw);
      vec_t v;
      v.addr = a; v.wdata = d; v.wr = w; v.kv = kv; v.kc = kc;
      v.chk = c; v.exp_rd = e; v.exp_ramwr = rw;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%02h required 0x%02h", nm, act, exp);
      end
   endtask

   // One bus cycle: drive, let one rising edge pass, return 1 time unit later.
   task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic w,
                      input logic kv, input logic [7:0] kc);
      cpu_addr = a; cpu_wdata = d; cpu_wr = w; key_valid = kv; key_code = kc;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [15:0] a);
      cyc(a, 8'h00, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      cyc(a, d, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic push(input logic [7:0] kc);
      cyc(IDLE, 8'h00, 1'b0, 1'b1, kc);
   endtask

   task automatic do_reset();
      cpu_addr = IDLE; cpu_wdata = 8'h00; cpu_wr = 1'b0;
      key_valid = 1'b0; key_code = 8'h00;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   vec_t tbl [23];

   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 8'(i + 8'h40);
      ram_rdata = 8'h5E;
      reset_n = 1'b0;
      cpu_addr = IDLE; cpu_wdata = 8'h00; cpu_wr = 1'b0;
      key_valid = 1'b0; key_code = 8'h00;

      //             addr     wdata  wr   kv   kc     chk  exp    ramwr
      tbl[0]  = mkv(16'h0010, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tbl[1]  = mkv(16'h0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0);
      tbl[2]  = mkv(16'hFF00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      tbl[3]  = mkv(IDLE,     8'h00, 1'b0, 1'b1, 8'h31, 1'b0, 8'h00, 1'b0);
      tbl[4]  = mkv(IDLE,     8'h00, 1'b0, 1'b1, 8'h32, 1'b0, 8'h00, 1'b0);
      tbl[5]  = mkv(16'hFF01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h31, 1'b0);
      tbl[6]  = mkv(16'hFF00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
      tbl[7]  = mkv(16'hFF01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h32, 1'b0);
      tbl[8]  = mkv(16'hFF00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      tbl[9]  = mkv(16'hFF04, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      tbl[10] = mkv(16'hFF04, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
      tbl[11] = mkv(16'hFF06, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      tbl[12] = mkv(16'hFF06, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
      tbl[13] = mkv(16'hFF05, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      tbl[14] = mkv(16'hFF05, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      tbl[15] = mkv(16'hFF07, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      tbl[16] = mkv(16'hFF01, 8'h99, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      tbl[17] = mkv(16'hFF00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      tbl[18] = mkv(16'hFF08, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tbl[19] = mkv(16'hFEFF, 8'h6B, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tbl[20] = mkv(16'hFF08, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0);
      tbl[21] = mkv(16'hFEFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h6B, 1'b0);
      tbl[22] = mkv(16'hFF01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

      // Reset state: outputs cleared while RAM data is non-zero.
      #1;
      chk("reset_rdata", cpu_rdata, 8'h00);
      chk("reset_irq",   {7'b0, o_irq}, 8'h00);
      chk("reset_led",   o_led, 8'h00);
      do_reset();

      // ---- Table-driven single-cycle accesses ----
      for (int i = 0; i < 23; i++) begin
         cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata; cpu_wr = tbl[i].wr;
         key_valid = tbl[i].kv;  key_code = tbl[i].kc;
         #1;
         chk($sformatf("vec%0d_ram_wr", i), {7'b0, ram_wr}, {7'b0, tbl[i].exp_ramwr});
         @(posedge clk);
         #1;
         if (tbl[i].chk) chk($sformatf("vec%0d_rdata", i), cpu_rdata, tbl[i].exp_rd);
      end

      // ---- Overflow: 9 pushes, 9th dropped, STAT write clears overflow ----
      do_reset();
      for (int i = 0; i < 9; i++) push(8'(8'h80 + i));
      rd(16'hFF00); chk("ovf_stat", cpu_rdata, 8'h07);
      wr(16'hFF00, 8'h00);
      rd(16'hFF00); chk("ovf_clr_stat", cpu_rdata, 8'h03);
      for (int i = 0; i < 8; i++) begin
         rd(16'hFF01); chk($sformatf("ovf_pop%0d", i), cpu_rdata, 8'(8'h80 + i));
         rd(16'hFF00); chk($sformatf("ovf_stat%0d", i), cpu_rdata, (i < 7) ? 8'h01 : 8'h00);
      end
      rd(16'hFF01); chk("ovf_9th_absent", cpu_rdata, 8'h00);

      // ---- Full FIFO, push coincident with first KEY read ----
      do_reset();
      for (int i = 0; i < 8; i++) push(8'(8'h90 + i));
      cyc(16'hFF01, 8'h00, 1'b0, 1'b1, 8'hAA);
      chk("full_pop_head", cpu_rdata, 8'h90);
      rd(16'hFF00); chk("full_pop_stat", cpu_rdata, 8'h03);
      for (int i = 0; i < 8; i++) begin
         rd(16'hFF01);
         chk($sformatf("full_drain%0d", i), cpu_rdata, (i < 7) ? 8'(8'h91 + i) : 8'hAA);
         rd(16'hFF00);
      end
      chk("full_drain_stat", cpu_rdata, 8'h00);

      // ---- Timer: load, tick, shadow, wrap, write-over-tick priority ----
      do_reset();
      wr(16'hFF03, 8'h12); wr(16'hFF02, 8'hFF);
      repeat (TDIV) rd(IDLE);
      rd(16'hFF02); chk("tmr_lo", cpu_rdata, 8'h00);
      rd(16'hFF03); chk("tmr_hi", cpu_rdata, 8'h13);
      wr(16'hFF03, 8'hFF); wr(16'hFF02, 8'hFF);
      repeat (TDIV) rd(IDLE);
      rd(16'hFF02); chk("tmr_wrap_lo", cpu_rdata, 8'h00);
      rd(16'hFF03); chk("tmr_wrap_hi", cpu_rdata, 8'h00);
      wr(16'hFF03, 8'h00); wr(16'hFF02, 8'h00);
      repeat (TDIV - 1) rd(IDLE);
      wr(16'hFF02, 8'h50);
      rd(16'hFF02); chk("tmr_prio_lo", cpu_rdata, 8'h50);
      rd(16'hFF03); chk("tmr_prio_hi", cpu_rdata, 8'h00);

      // ---- Held KEY read pops once ----
      do_reset();
      push(8'h41); push(8'h42);
      for (int i = 0; i < 5; i++) begin
         rd(16'hFF01); chk($sformatf("hold%0d", i), cpu_rdata, 8'h41);
      end
      rd(16'hFF00); chk("hold_stat", cpu_rdata, 8'h01);
      rd(16'hFF01); chk("hold_next", cpu_rdata, 8'h42);
      rd(16'hFF00); chk("hold_stat2", cpu_rdata, 8'h00);

      // ---- IRQ and asynchronous reset mid-read ----
      do_reset();
      wr(16'hFF06, 8'h01);
      rd(IDLE); chk("irq_idle", {7'b0, o_irq}, 8'h00);
      push(8'h55);
      rd(IDLE); chk("irq_set", {7'b0, o_irq}, 8'h01);
      wr(16'hFF04, 8'hC3); chk("led_val", o_led, 8'hC3);
      rd(16'hFF01); chk("irq_key", cpu_rdata, 8'h55);
      #3;
      reset_n = 1'b0;
      #1;
      chk("rst_irq",   {7'b0, o_irq}, 8'h00);
      chk("rst_led",   o_led, 8'h00);
      chk("rst_rdata", cpu_rdata, 8'h00);
      cpu_addr = IDLE;
      @(negedge clk);
      reset_n = 1'b1;
      rd(16'hFF00); chk("rst_stat", cpu_rdata, 8'h00);
      rd(IDLE);     chk("rst_irq_after", {7'b0, o_irq}, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/demo_io_bus.md
DEMO_IO_BUS -- requirements
Module: demo_io_bus

Interface
REQ-001 The module SHALL have these parameters, one per line: name, default, meaning.
- FIFO_DEPTH, 8, key FIFO entries (power of two).
- TICK_DIV, 25000, clock_25 cycles per timer tick (1 ms).

REQ-002 The module SHALL have these ports, one per line: name, direction, width, meaning.
- clock_25  in  1  single system clock, 25 MHz, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_addr  in  16  processor address (o_addr of demo_processor).
- cpu_wdata  in  8  processor write data.
- cpu_wr  in  1  processor write strobe.
- cpu_rdata  out  8  read data to processor (i_data).
- ram_addr  out  16  RAM address, equal to cpu_addr.
- ram_wdata  out  8  RAM write data, equal to cpu_wdata.
- ram_wr  out  1  RAM write enable.
- ram_rdata  in  8  RAM synchronous-read data, valid one cycle after address.
- key_valid  in  1  one-cycle key strobe.
- key_code  in  8  key code, sampled when key_valid=1.
- o_led  out  8  LED register.
- o_irq  out  1  key interrupt request.

Function
REQ-003 Region decode SHALL be: I/O when cpu_addr[15:3]=0x1FE0 (0xFF00-0xFF07); RAM otherwise.
REQ-004 ram_wr SHALL be combinational: cpu_wr AND RAM region. I/O writes SHALL never assert ram_wr.
REQ-005 Read latency SHALL be exactly one cycle for every address:
- The region select and I/O read value SHALL be registered on the edge.
- cpu_rdata SHALL show ram_rdata or the registered I/O value, according to the registered select.
REQ-006 I/O map SHALL be:
- FF00 STAT read: bit0 not_empty, bit1 full, bit2 overflow, others 0. Write of any value clears overflow.
- FF01 KEY read: FIFO head, or 0x00 when empty.
- FF02 TMR_LO read: timer[7:0]. The same edge latches timer[15:8] into a shadow register.
- FF03 TMR_HI read: the shadow register.
- FF04 LED: read/write, drives o_led.
- FF05: reads 0x00.
- FF06 IEN: read/write, bit0 only, upper bits read 0.
- FF07: reads 0x00.
Writes to read-only locations SHALL be ignored.
REQ-007 FIFO pop SHALL occur once per access: on the first cycle where cpu_addr=FF01 and cpu_wr=0, and the previous cycle's address was not FF01 as a read. Holding FF01 SHALL pop only once.
REQ-008 FIFO push on key_valid:
- Not full: key_code is stored and count increments.
- Full with no pop: the code is dropped, overflow (sticky) is set, and contents are unchanged.
- Full with a simultaneous pop: the push is accepted, count stays FIFO_DEPTH, and no overflow is set.
- Empty with a simultaneous pop: the pop is ignored and the push is accepted.
REQ-009 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Count SHALL range 0..FIFO_DEPTH.
REQ-010 Timer:
- A prescaler SHALL count 0..TICK_DIV-1.
- At TICK_DIV-1 it SHALL reset to 0 and the 16-bit timer SHALL increment, wrapping 0xFFFF to 0x0000.
REQ-011 A write to FF02 or FF03 SHALL load that timer byte and clear the prescaler. The write SHALL take priority over a tick in the same cycle.
REQ-012 o_irq SHALL be registered: IEN[0] AND not_empty, updated every edge.

Reset
REQ-013 reset_n=0 SHALL immediately clear all of the following: FIFO pointers, count, overflow, prescaler, timer, shadow, LED, IEN, read-select and read-data registers, and o_irq. cpu_rdata SHALL read 0x00.
REQ-014 Reset mid-access SHALL discard any pending pop or write. No state update SHALL occur on the first edge after reset_n rises unless an access is present on that edge.

Verification
REQ-015 The bench SHALL cover at least these scenarios:
- Push 0x31, 0x32, then read FF01 twice with FF00 between the reads -> 0x31, then 0x32. STAT reads 0x01 after the first read and 0x00 after the second.
- Push 9 keys with no reads -> STAT=0x07. The 9th code is absent. Write FF00 -> STAT=0x03.
- FIFO full, key_valid coincides with the first FF01 read cycle -> the old head is returned, count stays 8, overflow stays 0.
- Write FF03=0x12, FF02=0xFF, then wait TICK_DIV cycles -> read FF02 returns 0x00 and the following FF03 read returns 0x13.
- Hold FF01 for 5 cycles with 2 entries queued -> exactly one pop, and cpu_rdata is stable at the first entry.
- IEN=1 with one key pushed -> o_irq=1 one cycle after the push. Assert reset_n=0 mid-read -> o_irq, o_led and cpu_rdata go to 0 immediately.
